// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS word into ALU op + operands
// and registers them into EX with stall, flush and DIV occupancy.
//
// Ports: clk, rst_n (sync, active low); id_valid/id_ready handshake
// with id_instr, id_rs_data, id_rt_data; stall, flush controls;
// ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_wr_reg, ex_wr_en,
// ex_illegal, ex_fire toward the execute-stage ALU.
module alu_issue_stage #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [4:0]  ex_alu_op,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_wr_en,
  output logic        ex_illegal,
  output logic        ex_fire
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_LUI  = 5'h0A;
  localparam logic [4:0] OP_SLT  = 5'h0B;
  localparam logic [4:0] OP_SLTU = 5'h0C;
  localparam logic [4:0] OP_DIV  = 5'h0D;

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        legal;
  } dec_t;

  logic [5:0]  opc;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic        unused_rs;

  assign opc       = id_instr[31:26];
  assign rt        = id_instr[20:16];
  assign rd        = id_instr[15:11];
  assign shamt     = id_instr[10:6];
  assign funct     = id_instr[5:0];
  assign imm       = id_instr[15:0];
  assign imm_sx    = {{16{imm[15]}}, imm};
  assign imm_zx    = {16'b0, imm};
  // rs operand arrives already read from the register file
  assign unused_rs = ^id_instr[25:21];

  dec_t dec;

  always_comb begin
    dec       = '0;
    dec.legal = 1'b1;
    dec.a     = id_rs_data;
    unique case (opc)
      6'h00: begin
        dec.b    = id_rt_data;
        dec.dest = rd;
        unique case (funct)
          6'h20, 6'h21: dec.op = OP_ADD;
          6'h22, 6'h23: dec.op = OP_SUB;
          6'h24: dec.op = OP_AND;
          6'h25: dec.op = OP_OR;
          6'h26: dec.op = OP_XOR;
          6'h27: dec.op = OP_NOR;
          6'h2A: dec.op = OP_SLT;
          6'h2B: dec.op = OP_SLTU;
          6'h1A: dec.op = OP_DIV;
          6'h00: begin
            dec.op = OP_SLL;
            dec.a  = {27'b0, shamt};
          end
          6'h02: begin
            dec.op = OP_SRL;
            dec.a  = {27'b0, shamt};
          end
          6'h03: begin
            dec.op = OP_SRA;
            dec.a  = {27'b0, shamt};
          end
          6'h04: dec.op = OP_SLL;
          6'h06: dec.op = OP_SRL;
          6'h07: dec.op = OP_SRA;
          default: dec.legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin
        dec.op   = OP_ADD;
        dec.b    = imm_sx;
        dec.dest = rt;
      end
      6'h0A: begin
        dec.op   = OP_SLT;
        dec.b    = imm_sx;
        dec.dest = rt;
      end
      6'h0B: begin
        dec.op   = OP_SLTU;
        dec.b    = imm_sx;
        dec.dest = rt;
      end
      6'h0C: begin
        dec.op   = OP_AND;
        dec.b    = imm_zx;
        dec.dest = rt;
      end
      6'h0D: begin
        dec.op   = OP_OR;
        dec.b    = imm_zx;
        dec.dest = rt;
      end
      6'h0E: begin
        dec.op   = OP_XOR;
        dec.b    = imm_zx;
        dec.dest = rt;
      end
      6'h0F: begin
        dec.op   = OP_LUI;
        dec.a    = '0;
        dec.b    = imm_zx;
        dec.dest = rt;
      end
      default: dec.legal = 1'b0;
    endcase
    if (!dec.legal) begin
      dec.op   = OP_NOP;
      dec.a    = '0;
      dec.b    = '0;
      dec.dest = '0;
    end
  end

  logic [CW-1:0] div_cnt;
  logic          div_busy;

  assign div_busy = (div_cnt != '0);
  assign id_ready = !stall && !div_busy;
  assign ex_fire  = ex_valid && !div_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_alu_a   <= '0;
      ex_alu_b   <= '0;
      ex_alu_op  <= OP_NOP;
      ex_wr_reg  <= '0;
      ex_wr_en   <= 1'b0;
      ex_illegal <= 1'b0;
      div_cnt    <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_alu_op  <= OP_NOP;
      div_cnt    <= '0;
    end else if (stall) begin
      // hold everything, including the DIV countdown
    end else if (div_busy) begin
      div_cnt <= div_cnt - 1'b1;
    end else if (id_valid) begin
      ex_valid   <= 1'b1;
      ex_alu_a   <= dec.a;
      ex_alu_b   <= dec.b;
      ex_alu_op  <= dec.op;
      ex_wr_reg  <= dec.dest;
      ex_wr_en   <= dec.legal && (dec.dest != '0);
      ex_illegal <= !dec.legal;
      div_cnt    <= (dec.op == OP_DIV) ? DIV_LOAD : '0;
    end else begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_alu_op  <= OP_NOP;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, DIV occupancy,
// stall/flush priority and reset, with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [4:0]  ex_alu_op;
  logic [4:0]  ex_wr_reg;
  logic        ex_wr_en;
  logic        ex_illegal;
  logic        ex_fire;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = 32'h2025FFFD;
  localparam logic [31:0] I_ORI  = 32'h34028000;
  localparam logic [31:0] I_SRA  = 32'h00041903;
  localparam logic [31:0] I_ZERO = 32'h00000000;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_DIV  = 32'h0022201A;
  localparam logic [31:0] I_ADD  = 32'h00223020;

  always #5 clk = ~clk;

  alu_issue_stage #(.DIV_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .stall      (stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_alu_a   (ex_alu_a),
    .ex_alu_b   (ex_alu_b),
    .ex_alu_op  (ex_alu_op),
    .ex_wr_reg  (ex_wr_reg),
    .ex_wr_en   (ex_wr_en),
    .ex_illegal (ex_illegal),
    .ex_fire    (ex_fire)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt);
    id_valid   = v;
    id_instr   = ins;
    id_rs_data = rs;
    id_rt_data = rt;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, I_ADDI, 32'd10, 32'd0);
    tick();
    tick();
    check("rst_valid",   32'(ex_valid),   32'd0);
    check("rst_a",       ex_alu_a,        32'd0);
    check("rst_b",       ex_alu_b,        32'd0);
    check("rst_op",      32'(ex_alu_op),  32'd0);
    check("rst_wr_reg",  32'(ex_wr_reg),  32'd0);
    check("rst_wr_en",   32'(ex_wr_en),   32'd0);
    check("rst_illegal", 32'(ex_illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(id_ready), 32'd1);

    tick();
    check("addi_op",   32'(ex_alu_op), 32'h01);
    check("addi_a",    ex_alu_a,       32'd10);
    check("addi_b",    ex_alu_b,       32'hFFFFFFFD);
    check("addi_reg",  32'(ex_wr_reg), 32'd5);
    check("addi_wen",  32'(ex_wr_en),  32'd1);
    check("addi_fire", 32'(ex_fire),   32'd1);

    drive(1'b1, I_ORI, 32'd0, 32'd0);
    tick();
    check("ori_op",  32'(ex_alu_op), 32'h04);
    check("ori_a",   ex_alu_a,       32'd0);
    check("ori_b",   ex_alu_b,       32'h00008000);
    check("ori_reg", 32'(ex_wr_reg), 32'd2);

    drive(1'b1, I_SRA, 32'h12345678, 32'h80000000);
    tick();
    check("sra_op",  32'(ex_alu_op), 32'h09);
    check("sra_a",   ex_alu_a,       32'd4);
    check("sra_b",   ex_alu_b,       32'h80000000);
    check("sra_reg", 32'(ex_wr_reg), 32'd3);
    check("sra_wen", 32'(ex_wr_en),  32'd1);

    drive(1'b1, I_ZERO, 32'h0, 32'h0);
    tick();
    check("nop_op",    32'(ex_alu_op),  32'h07);
    check("nop_wen",   32'(ex_wr_en),   32'd0);
    check("nop_valid", 32'(ex_valid),   32'd1);
    check("nop_ill",   32'(ex_illegal), 32'd0);

    drive(1'b1, I_ILL, 32'h55, 32'h66);
    tick();
    check("ill_flag",  32'(ex_illegal), 32'd1);
    check("ill_op",    32'(ex_alu_op),  32'h00);
    check("ill_wen",   32'(ex_wr_en),   32'd0);
    check("ill_valid", 32'(ex_valid),   32'd1);
    check("ill_a",     ex_alu_a,        32'd0);
    check("ill_b",     ex_alu_b,        32'd0);

    drive(1'b0, I_ADD, 32'h0, 32'h0);
    tick();
    check("bubble_valid", 32'(ex_valid), 32'd0);

    // back-to-back DIV then ADD
    drive(1'b1, I_DIV, 32'd100, 32'd7);
    tick();
    drive(1'b1, I_ADD, 32'd100, 32'd7);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("div_valid%0d", c), 32'(ex_valid), 32'd1);
      check($sformatf("div_op%0d", c), 32'(ex_alu_op), 32'h0D);
      check($sformatf("div_fire%0d", c), 32'(ex_fire),
            (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("div_ready%0d", c), 32'(id_ready),
            (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("after_div_op",  32'(ex_alu_op), 32'h01);
    check("after_div_reg", 32'(ex_wr_reg), 32'd6);
    check("after_div_a",   ex_alu_a,       32'd100);
    check("after_div_b",   ex_alu_b,       32'd7);

    // DIV with a 2-cycle stall in the middle
    drive(1'b1, I_DIV, 32'd9, 32'd3);
    tick();
    drive(1'b0, I_ADD, 32'd0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("sdiv_valid%0d", c), 32'(ex_valid), 32'd1);
      check($sformatf("sdiv_op%0d", c), 32'(ex_alu_op), 32'h0D);
      check($sformatf("sdiv_fire%0d", c), 32'(ex_fire),
            (c == 6) ? 32'd1 : 32'd0);
      check($sformatf("sdiv_ready%0d", c), 32'(id_ready),
            (c == 6) ? 32'd1 : 32'd0);
      stall = (c == 2 || c == 3);
      tick();
    end
    check("sdiv_end_valid", 32'(ex_valid), 32'd0);

    // flush in DIV cycle 2 aborts it
    drive(1'b1, I_DIV, 32'd9, 32'd3);
    tick();
    drive(1'b1, I_ADD, 32'd1, 32'd2);
    tick();
    check("fdiv_c2_ready", 32'(id_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fdiv_valid", 32'(ex_valid),  32'd0);
    check("fdiv_ready", 32'(id_ready),  32'd1);
    check("fdiv_op",    32'(ex_alu_op), 32'h00);
    check("fdiv_wen",   32'(ex_wr_en),  32'd0);

    // flush and stall together: flush wins, ID word dropped
    drive(1'b1, I_ADDI, 32'd10, 32'd0);
    tick();
    check("fs_pre_valid", 32'(ex_valid), 32'd1);
    drive(1'b1, I_ORI, 32'd0, 32'd0);
    stall = 1'b1;
    flush = 1'b1;
    #1;
    check("fs_ready_stall", 32'(id_ready), 32'd0);
    tick();
    check("fs_valid", 32'(ex_valid), 32'd0);
    check("fs_wen",   32'(ex_wr_en), 32'd0);
    stall = 1'b0;
    tick();
    check("flush_drop_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;

    // reset during DIV occupancy
    drive(1'b1, I_DIV, 32'd9, 32'd3);
    tick();
    check("rdiv_ready", 32'(id_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rdiv_valid", 32'(ex_valid), 32'd0);
    check("rdiv_a",     ex_alu_a,      32'd0);
    check("rdiv_rdy",   32'(id_ready), 32'd1);
    rst_n = 1'b1;
    drive(1'b0, I_ZERO, 32'd0, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that decodes a MIPS instruction into the 5-bit ALU op code and operand pair consumed by the execute-stage ALU, and registers them into the EX stage. It is the issuing end of the ALU interface. It holds the EX register for stalls, flushes, and a parameterised multi-cycle DIV occupancy, and exposes a ready/valid handshake toward the ID stage.

## Interface
- DIV_CYCLES, 4: cycles a DIV occupies EX (≥1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage accepts this cycle; combinational: !stall && !div_busy.
- id_instr  in  32  instruction word.
- id_rs_data  in  32  register-file value of rs.
- id_rt_data  in  32  register-file value of rt.
- stall  in  1  downstream stall; hold EX register.
- flush  in  1  kill EX contents (branch/exception); has priority over stall.
- ex_valid  out  1  EX register holds a live instruction.
- ex_alu_a  out  32  ALU operand a.
- ex_alu_b  out  32  ALU operand b.
- ex_alu_op  out  5  ALU op code.
- ex_wr_reg  out  5  destination register.
- ex_wr_en  out  1  writeback enable (0 if dest is r0, illegal, or bubble).
- ex_illegal  out  1  undecodable instruction in EX.
- ex_fire  out  1  ex_valid && !div_busy: ALU result is final this cycle.

## Operation
- Op codes: NOP 00, ADD 01, SUB 02, AND 03, OR 04, XOR 05, NOR 06, SLL 07, SRL 08, SRA 09, LUI 0A, SLT 0B, SLTU 0C, DIV 0D.
- R-type (opcode 0x00), dest = rd, a = rs_data, b = rt_data unless noted:
  - funct 20/21 → ADD; 22/23 → SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU; 1A DIV.
  - 00/02/03 → SLL/SRL/SRA with a = {27'b0, shamt}.
  - 04/06/07 → SLLV/SRLV/SRAV → SLL/SRL/SRA with a = rs_data.
- I-type, dest = rt, a = rs_data, imm = instr[15:0]:
  - 08/09 → ADD, b = sign-ext imm.
  - 0A/0B → SLT/SLTU, b = sign-ext imm.
  - 0C/0D/0E → AND/OR/XOR, b = zero-ext imm.
  - 0F → LUI, b = {16'b0, imm}, a = 0.
- Any other opcode or funct: op NOP, a = b = 0, wr_en 0, ex_illegal 1, ex_valid 1.
- ex_wr_en = 1 only for a legal decode with dest ≠ 0. Word 0x00000000 therefore decodes as SLL with wr_en 0.
- div_busy: internal down-counter div_cnt ≠ 0. On loading a DIV, div_cnt ← DIV_CYCLES−1.

## Timing
- Reset (rst_n = 0 at a clock edge): ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_wr_reg, ex_wr_en, ex_illegal = 0; div_cnt = 0. After reset, id_ready = !stall.
- Per-edge priority:
  1. flush: ex_valid, ex_wr_en, ex_illegal ← 0; op ← NOP; div_cnt ← 0.
  2. stall: all state held, including div_cnt.
  3. div_busy: EX register held; div_cnt ← div_cnt−1.
  4. id_valid: load decoded instruction, ex_valid ← 1.
  5. otherwise: bubble (ex_valid 0, wr_en 0, illegal 0, op NOP).
- Latency: instruction accepted at edge N is visible on ex_* after edge N.
- Transfer occurs only when id_valid && id_ready. ID must hold id_instr and operands while id_ready = 0.
- DIV occupies EX for exactly DIV_CYCLES unstalled cycles. ex_fire is asserted only in the last of them. id_ready is low for the first DIV_CYCLES−1 of them. With DIV_CYCLES = 1, DIV behaves like any other op.
- Flush during DIV occupancy aborts it immediately: id_ready is 1 on the next cycle (absent stall).
- Flush and id_valid on the same edge: the instruction is dropped (not loaded).
- Reset during DIV occupancy clears div_cnt, identical to flush plus zeroing of all outputs.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with id_valid = 1 → all ex_* outputs 0, then release; id_ready = 1.
- addi r5, r1, −3 (0x2025FFFD), rs_data = 10 → next cycle op 01, a = 10, b = 0xFFFFFFFD, wr_reg 5, wr_en 1. ori r2, r0, 0x8000 → b = 0x00008000, op 04.
- sra r3, r4, 4 (0x00041903), rt_data = 0x80000000 → op 09, a = 4, b = 0x80000000, wr_reg 3. Word 0x00000000 → op 07, wr_en 0, ex_valid 1.
- DIV (funct 1A) with DIV_CYCLES = 4 and back-to-back id_valid → ex_valid held 4 cycles; id_ready low for 3; ex_fire high only in cycle 4; next instruction appears in cycle 5.
- Stall asserted for 2 cycles mid-DIV → div_cnt frozen, DIV occupancy extends to 6 cycles. Flush in DIV cycle 2 → ex_valid 0 next cycle, id_ready 1.
- Opcode 0x3F → ex_illegal 1, op 00, wr_en 0. Flush and stall together → flush wins, ex_valid 0.
